ray_setup: RTL and testbench
============================

# ray_setup

Per-ray preprocessing stage that feeds `ray_bbox_intersect`. It accepts a ray origin and direction, and computes the 18.18 reciprocal of each direction component with three parallel bit-serial dividers. It also produces the per-axis `div_by_zero` flags. It then holds `ray_orig`, `inv_ray_dir` and `div_by_zero` stable for the intersector, honouring the intersector's `stall`.

## Interface
Parameters:
- `IN_FRAC`, 16: fractional bits of `vec3` components (signed 32-bit); must match the typedef.
- `OUT_FRAC`, 18: fractional bits of `vec3_18_18` components (signed 36-bit); must match the typedef.
- `ITERS`, 35: quotient bits produced, one per cycle (IN_FRAC + OUT_FRAC + 1).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `ray_orig_in` and `ray_dir_in` are valid.
- `in_ready` out 1: high only in IDLE; a transfer happens when `in_valid && in_ready`.
- `ray_orig_in` in `vec3`: ray origin.
- `ray_dir_in` in `vec3`: ray direction, Q16.16 signed.
- `stall` in 1: downstream stall, same meaning as on `ray_bbox_intersect`.
- `out_valid` out 1: outputs below hold a complete result.
- `ray_orig` out `vec3`: registered copy of the accepted origin.
- `inv_ray_dir` out `vec3_18_18`: per-axis reciprocal in Q18.18.
- `div_by_zero` out 3: bit0 = x, bit1 = y, bit2 = z; set when that direction component is 0.

## Operation
- The FSM has three states:
  - IDLE: `in_ready` = 1. On a transfer, capture the origin. Per axis, capture sign, magnitude |d| (33-bit unsigned, so d = −2^31 is exact) and the zero flag. Clear the partial remainders and quotients, set the iteration counter to `ITERS`−1, and go to DIVIDE.
  - DIVIDE: each cycle every axis runs one restoring-division step on the dividend 2^34 (1.0 in output units, i.e. 2^(IN_FRAC+OUT_FRAC)), MSB first. The counter decrements; on count 0 go to DONE.
  - DONE: `out_valid` = 1. If `stall` = 0, go to IDLE (result consumed). If `stall` = 1, stay with all outputs frozen.
- Result per axis:
  - Quotient = floor(2^34 / |d|), truncated toward zero.
  - If the sign is negative, `inv` = −quotient (two's complement, 36-bit).
  - Zero axis: `inv` = 0, `div_by_zero` bit = 1. The divider for that axis is masked and never divides by 0.
- Range: the maximum quotient is 2^34 (|d| = 1 LSB), which fits in signed 36-bit. No saturation logic is required.
- The divider registers update only in DIVIDE. The output registers load once, on the DIVIDE→DONE transition, and are otherwise held.
- `in_valid` in any state other than IDLE is ignored and the input is not consumed.
- `stall` outside DONE has no effect.
- Reset mid-operation abandons the ray with no partial output.
- Reset values:
  - State IDLE, `in_ready` = 1, `out_valid` = 0.
  - `ray_orig` = `vec3_default`, `inv_ray_dir` = 0, `div_by_zero` = 3'b000.
  - Counter, remainders and quotients = 0.

## Timing
- Accept on edge T. DIVIDE occupies cycles T+1 … T+35. `out_valid` rises after edge T+35 and is visible in cycle T+36.
- Minimum ray-to-ray period is 37 cycles: accept, 35 DIVIDE cycles, one DONE cycle with `stall` = 0. The next `in_ready` is high in cycle T+37.
- The `stall` release edge drops `out_valid` on that same edge.
- No combinational path from any input to any output except `in_ready`, which depends on state only.

## Structure
- The shared data-macros package already holds the `vec3`, `vec3_18_18` and `vec3_default` types. Add `RECIP_ONE` = 2^34 and `RECIP_ITERS` = 35 there.
- Add one sub-module, `fxp_recip_step`: a single-axis bit-serial restoring divider slice (remainder/quotient registers, enable, zero-mask), instantiated three times.
- FSM, counter and output registers live in `ray_setup`.

## Test plan
- Direction (1.0, 0, 0) = (65536, 0, 0), origin default. Required: `inv_ray_dir` = (262144, 0, 0), `div_by_zero` = 3'b110, `out_valid` exactly 36 cycles after accept. Chain into `ray_bbox_intersect` with box min (65536, −65536, −65536), max (131072, 65536, 65536) and check `hit` = 1.
- Direction (2.0, −0.5, 3.0) = (131072, −32768, 196608). Required: inv = (131072, −524288, 87381), `div_by_zero` = 3'b000.
- Boundary magnitudes: d = 1 gives inv = 17179869184. d = −2^31 gives inv = −8.
- Stall: assert `stall` before DONE and hold for 10 cycles. Required: `out_valid` and outputs frozen for all 10 cycles, `in_ready` = 0, and a second `in_valid` ignored. Release: `out_valid` drops on the next edge, `in_ready` rises.
- Reset mid-DIVIDE at cycle T+20. Required: the next cycle shows IDLE, `out_valid` = 0 and all outputs at reset values. A new ray then completes correctly after a full 36 cycles.
- All-zero direction. Required: `div_by_zero` = 3'b111, `inv_ray_dir` = 0, latency still 36 cycles.

Source files
------------

// File: rtl/ray_setup_pkg.sv
// Shared ray data types plus the reciprocal-divider constants and FSM state encoding.
package ray_setup_pkg;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vec3;

    typedef struct packed {
        logic signed [35:0] x;
        logic signed [35:0] y;
        logic signed [35:0] z;
    } vec3_18_18;

    localparam vec3 vec3_default = '{x: 32'sd0, y: 32'sd0, z: 32'sd0};

    // 1.0 in Q18.18 output units seen from a Q16.16 divisor: 2^(16+18)
    localparam logic [34:0] RECIP_ONE   = 35'h4_0000_0000;
    localparam int          RECIP_ITERS = 35;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } setup_state_e;

endpackage

// File: rtl/fxp_recip_step.sv
// One axis of the bit-serial restoring divider: one quotient bit per enabled cycle, MSB first.
module fxp_recip_step
    import ray_setup_pkg::*;
#(
    parameter int DIV_W = 33,
    parameter int QUO_W = RECIP_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             zero,
    input  logic             din_bit,
    input  logic [DIV_W-1:0] divisor,
    output logic [QUO_W-1:0] quo_d
);

    localparam int REM_W = DIV_W + 1;

    logic [REM_W-1:0] rem_q, rem_d;
    logic [QUO_W-1:0] quo_q;
    logic [REM_W:0]   trial;
    logic [REM_W:0]   div_ext;

    always_comb begin
        trial   = {rem_q, din_bit};
        div_ext = {2'b00, divisor};
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (clr) begin
            rem_d = '0;
            quo_d = '0;
        end else if (en && !zero) begin
            // The zero mask keeps a 0 divisor out of the datapath entirely
            if (trial >= div_ext) begin
                rem_d = REM_W'(trial - div_ext);
                quo_d = {quo_q[QUO_W-2:0], 1'b1};
            end else begin
                rem_d = trial[REM_W-1:0];
                quo_d = {quo_q[QUO_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

endmodule

// File: rtl/ray_setup.sv
// Per-ray setup: captures origin/direction, computes Q18.18 reciprocals of the direction
// with three serial dividers, and holds the result for the intersector under stall.
module ray_setup
    import ray_setup_pkg::*;
#(
    parameter int IN_FRAC  = 16,
    parameter int OUT_FRAC = 18,
    parameter int ITERS    = 35
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  vec3       ray_orig_in,
    input  vec3       ray_dir_in,
    input  logic      stall,
    output logic      out_valid,
    output vec3       ray_orig,
    output vec3_18_18 inv_ray_dir,
    output logic [2:0] div_by_zero
);

    localparam int QUO_W = IN_FRAC + OUT_FRAC + 1;
    localparam int CNT_W = $clog2(ITERS);

    setup_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    vec3               orig_q, orig_d;
    vec3               ray_orig_q, ray_orig_d;
    vec3_18_18         inv_q, inv_d;
    logic [2:0]        neg_q, neg_d;
    logic [2:0]        zero_q, zero_d;
    logic [2:0]        dbz_q, dbz_d;
    logic [32:0]       mag_q [3];
    logic [32:0]       mag_d [3];
    logic signed [31:0] dir_in [3];
    logic [QUO_W-1:0]  quo_d [3];
    logic signed [35:0] inv_ax [3];
    logic              accept;
    logic              div_en;
    logic              din_bit;

    assign dir_in[0] = ray_dir_in.x;
    assign dir_in[1] = ray_dir_in.y;
    assign dir_in[2] = ray_dir_in.z;

    assign accept  = (state_q == ST_IDLE) && in_valid;
    assign div_en  = (state_q == ST_DIVIDE);
    // The dividend is a single 1 at bit 34; the counter doubles as its bit index
    assign din_bit = RECIP_ONE[cnt_q];

    for (genvar g = 0; g < 3; g++) begin : g_axis
        fxp_recip_step #(.DIV_W(33), .QUO_W(QUO_W)) u_step (
            .clk     (clk),
            .rst     (rst),
            .clr     (accept),
            .en      (div_en),
            .zero    (zero_q[g]),
            .din_bit (din_bit),
            .divisor (mag_q[g]),
            .quo_d   (quo_d[g])
        );
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (zero_q[i]) begin
                inv_ax[i] = '0;
            end else if (neg_q[i]) begin
                inv_ax[i] = -$signed({1'b0, quo_d[i]});
            end else begin
                inv_ax[i] = $signed({1'b0, quo_d[i]});
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        orig_d     = orig_q;
        ray_orig_d = ray_orig_q;
        inv_d      = inv_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        dbz_d      = dbz_q;
        for (int i = 0; i < 3; i++) mag_d[i] = mag_q[i];

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    orig_d = ray_orig_in;
                    for (int i = 0; i < 3; i++) begin
                        neg_d[i]  = dir_in[i][31];
                        zero_d[i] = (dir_in[i] == 32'sd0);
                        // 33-bit magnitude so that -2^31 stays exact
                        mag_d[i]  = dir_in[i][31] ? (33'd0 - {dir_in[i][31], dir_in[i]})
                                                  : {1'b0, dir_in[i]};
                    end
                    cnt_d   = CNT_W'(ITERS - 1);
                    state_d = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    ray_orig_d = orig_q;
                    inv_d      = '{x: inv_ax[0], y: inv_ax[1], z: inv_ax[2]};
                    dbz_d      = zero_q;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            orig_q     <= vec3_default;
            ray_orig_q <= vec3_default;
            inv_q      <= '0;
            neg_q      <= '0;
            zero_q     <= '0;
            dbz_q      <= '0;
            for (int i = 0; i < 3; i++) mag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            orig_q     <= orig_d;
            ray_orig_q <= ray_orig_d;
            inv_q      <= inv_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            dbz_q      <= dbz_d;
            for (int i = 0; i < 3; i++) mag_q[i] <= mag_d[i];
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign ray_orig    = ray_orig_q;
    assign inv_ray_dir = inv_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ray_setup.sv
// Directed bench for ray_setup: reciprocal values, zero flags, latency, stall hold and reset.
module tb_ray_setup;
    import ray_setup_pkg::*;

    logic      clk;
    logic      rst;
    logic      in_valid;
    logic      in_ready;
    vec3       ray_orig_in;
    vec3       ray_dir_in;
    logic      stall;
    logic      out_valid;
    vec3       ray_orig;
    vec3_18_18 inv_ray_dir;
    logic [2:0] div_by_zero;

    int checks = 0;
    int errors = 0;

    ray_setup dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ray_orig_in (ray_orig_in),
        .ray_dir_in  (ray_dir_in),
        .stall       (stall),
        .out_valid   (out_valid),
        .ray_orig    (ray_orig),
        .inv_ray_dir (inv_ray_dir),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec3 mk(input int x, input int y, input int z);
        vec3 v;
        v.x = x;
        v.y = y;
        v.z = z;
        return v;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one ray for exactly one edge; caller guarantees IDLE
    task automatic send(input vec3 o, input vec3 d);
        chk("ready_before_send", {63'd0, in_ready}, 64'sd1);
        ray_orig_in = o;
        ray_dir_in  = d;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
    endtask

    // Expects out_valid low through cycle T+35 and high in cycle T+36
    task automatic wait_done(input string tag);
        for (int k = 0; k < 34; k++) step();
        chk({tag, "_valid_early"}, {63'd0, out_valid}, 64'sd0);
        step();
        chk({tag, "_valid_on_time"}, {63'd0, out_valid}, 64'sd1);
    endtask

    task automatic chk_inv(input string tag, input logic signed [63:0] ex,
                           input logic signed [63:0] ey, input logic signed [63:0] ez,
                           input logic [2:0] edbz);
        chk({tag, "_inv_x"}, 64'(inv_ray_dir.x), ex);
        chk({tag, "_inv_y"}, 64'(inv_ray_dir.y), ey);
        chk({tag, "_inv_z"}, 64'(inv_ray_dir.z), ez);
        chk({tag, "_dbz"}, {61'd0, div_by_zero}, {61'd0, edbz});
    endtask

    task automatic release_idle(input string tag);
        step();
        chk({tag, "_valid_drop"}, {63'd0, out_valid}, 64'sd0);
        chk({tag, "_ready_back"}, {63'd0, in_ready}, 64'sd1);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        stall       = 1'b0;
        ray_orig_in = vec3_default;
        ray_dir_in  = vec3_default;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", {63'd0, in_ready}, 64'sd1);
        chk("rst_valid", {63'd0, out_valid}, 64'sd0);
        chk("rst_orig_x", 64'(ray_orig.x), 64'(vec3_default.x));
        chk_inv("rst", 64'sd0, 64'sd0, 64'sd0, 3'b000);

        // 1.0 along x
        send(vec3_default, mk(65536, 0, 0));
        wait_done("unit_x");
        chk_inv("unit_x", 64'sd262144, 64'sd0, 64'sd0, 3'b110);
        release_idle("unit_x");

        // Mixed signs and a non-exact quotient
        send(mk(1, -2, 3), mk(131072, -32768, 196608));
        wait_done("mixed");
        chk_inv("mixed", 64'sd131072, -64'sd524288, 64'sd87381, 3'b000);
        chk("mixed_orig_x", 64'(ray_orig.x), 64'sd1);
        chk("mixed_orig_y", 64'(ray_orig.y), -64'sd2);
        chk("mixed_orig_z", 64'(ray_orig.z), 64'sd3);
        release_idle("mixed");

        // Extreme magnitudes: 1 LSB and -2^31
        send(vec3_default, mk(1, 32'h8000_0000, 0));
        wait_done("bound");
        chk_inv("bound", 64'sd17179869184, -64'sd8, 64'sd0, 3'b100);
        release_idle("bound");

        // Stall raised before DONE; a second ray offered while stalled
        stall = 1'b1;
        send(mk(7, 8, 9), mk(-65536, 65536, 0));
        wait_done("stall");
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                ray_orig_in = mk(100, 100, 100);
                ray_dir_in  = mk(1, 1, 1);
                in_valid    = 1'b1;
            end
            step();
            chk("stall_valid_held", {63'd0, out_valid}, 64'sd1);
            chk("stall_ready_low", {63'd0, in_ready}, 64'sd0);
            chk("stall_inv_x_held", 64'(inv_ray_dir.x), -64'sd262144);
            chk("stall_orig_held", 64'(ray_orig.x), 64'sd7);
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        release_idle("stall");
        chk_inv("stall_after", -64'sd262144, 64'sd262144, 64'sd0, 3'b100);

        // Reset in the middle of DIVIDE at T+20
        send(mk(5, 5, 5), mk(131072, -32768, 196608));
        for (int k = 0; k < 19; k++) step();
        chk("mid_valid_low", {63'd0, out_valid}, 64'sd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", {63'd0, in_ready}, 64'sd1);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'sd0);
        chk("mid_rst_orig_x", 64'(ray_orig.x), 64'(vec3_default.x));
        chk_inv("mid_rst", 64'sd0, 64'sd0, 64'sd0, 3'b000);
        send(mk(4, 0, 0), mk(65536, 0, -131072));
        wait_done("after_rst");
        chk_inv("after_rst", 64'sd262144, 64'sd0, -64'sd131072, 3'b010);
        chk("after_rst_orig_x", 64'(ray_orig.x), 64'sd4);
        release_idle("after_rst");

        // All-zero direction
        send(vec3_default, mk(0, 0, 0));
        wait_done("zero");
        chk_inv("zero", 64'sd0, 64'sd0, 64'sd0, 3'b111);
        release_idle("zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
